binary2bcd_iter: RTL

BINARY2BCD_ITER -- requirements
Module: binary2bcd_iter

---
 rtl/binary2bcd_iter_pkg.sv | 13 +
 rtl/binary2bcd_iter_digit_adj.sv | 10 +
 rtl/binary2bcd_iter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/binary2bcd_iter_pkg.sv
// Shared constants for the iterative binary-to-BCD converter:
// default word size and the FSM state encodings.
package binary2bcd_iter_pkg;

    localparam int WORDSIZE = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/binary2bcd_iter_digit_adj.sv
// Double-dabble digit correction: add 3 to any digit of 5 or more
// so the following left shift carries correctly into the next digit.
module bcd_digit_adj (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    assign d_o = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;

endmodule

// File: rtl/binary2bcd_iter.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Results stay registered until the next conversion completes.
module binary2bcd_iter
    import binary2bcd_iter_pkg::*;
#(
    parameter int WIDTH  = WORDSIZE,
    parameter int DIGITS = 6,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      in,
    output logic                  ready,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic                  overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int DW = 4 * DIGITS;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [DW-1:0]   dig_q, dig_d;
    logic            acc_q, acc_d;
    logic            sign_q, sign_d;
    logic [DW-1:0]   bcd_q, bcd_d;
    logic            neg_q, neg_d;
    logic            ovf_q, ovf_d;

    logic [DW-1:0]    adj;
    logic [DW-1:0]    dig_sh;
    logic             carry;
    logic             in_neg;
    logic [WIDTH-1:0] in_mag;
    logic             accept;
    logic             go_idle;
    logic             in_shift;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i (dig_q[4*g +: 4]),
            .d_o (adj[4*g +: 4])
        );
    end

    // Negation in WIDTH bits maps the most negative input to 2^(WIDTH-1).
    assign in_neg = (SIGNED != 0) && in[WIDTH-1];
    assign in_mag = in_neg ? (~in + {{(WIDTH-1){1'b0}}, 1'b1}) : in;

    assign dig_sh   = {adj[DW-2:0], mag_q[WIDTH-1]};
    assign carry    = adj[DW-1];
    assign in_shift = (state_q == SHIFT);
    assign accept   = start && !in_shift;
    assign go_idle  = (state_q == DONE) && !start;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mag_d   = mag_q;
        dig_d   = dig_q;
        acc_d   = acc_q;
        sign_d  = sign_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        unique case (1'b1)
            accept: begin
                mag_d   = in_mag;
                sign_d  = in_neg;
                dig_d   = '0;
                acc_d   = 1'b0;
                cnt_d   = CW'(WIDTH);
                state_d = SHIFT;
            end
            in_shift: begin
                dig_d = dig_sh;
                mag_d = {mag_q[WIDTH-2:0], 1'b0};
                acc_d = acc_q | carry;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d   = dig_sh;
                    neg_d   = sign_q;
                    ovf_d   = acc_q | carry;
                    state_d = DONE;
                end
            end
            go_idle: begin
                state_d = IDLE;
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mag_q   <= '0;
            dig_q   <= '0;
            acc_q   <= 1'b0;
            sign_q  <= 1'b0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mag_q   <= mag_d;
            dig_q   <= dig_d;
            acc_q   <= acc_d;
            sign_q  <= sign_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready     = !in_shift;
    assign out_valid = (state_q == DONE);
    assign bcd       = bcd_q;
    assign neg       = neg_q;
    assign overflow  = ovf_q;

endmodule
